// File: rtl/counter_pkg.sv
// Shared types for the multi-channel counter: counting modes and mode width.
// Imported by multi_counter and counter_channel.
package counter_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_UP       = 2'd0,
        MODE_DOWN     = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_HOLD     = 2'd3
    } mode_e;

endpackage

// File: rtl/counter_channel.sv
// One counter channel: mode/wrap/direction config, registered count and tc.
// Ports: clk_i, rst_i, step_i (tick & enable), cfg_we_i/cfg_load_i (this
// channel selected), cfg_mode_i, cfg_wrap_i, cfg_value_i -> count_o, tc_o.
module counter_channel
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              step_i,
    input  logic              cfg_we_i,
    input  logic              cfg_load_i,
    input  logic [MODE_W-1:0] cfg_mode_i,
    input  logic              cfg_wrap_i,
    input  logic [WIDTH-1:0]  cfg_value_i,
    output logic [WIDTH-1:0]  count_o,
    output logic              tc_o
);

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    mode_e            mode_q;
    logic             wrap_q;
    logic             dir_q;   // 0 = counting up, 1 = counting down
    logic [WIDTH-1:0] count_q;
    logic             tc_q;

    logic             active;
    logic             term;
    logic             dir_d;
    logic [WIDTH-1:0] count_d;
    logic             load;

    assign load   = cfg_we_i && cfg_load_i;
    assign active = step_i && (mode_q != MODE_HOLD);

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        term    = 1'b0;
        if (active) begin
            unique case (mode_q)
                MODE_UP: begin
                    term = (count_q == MAX);
                    if (!term || wrap_q)
                        count_d = count_q + ONE;
                end
                MODE_DOWN: begin
                    term = (count_q == '0);
                    if (!term || wrap_q)
                        count_d = count_q - ONE;
                end
                MODE_PINGPONG: begin
                    // Reversal steps away from the bound in the same cycle
                    if (!dir_q) begin
                        term = (count_q == MAX);
                        if (term) begin
                            dir_d   = 1'b1;
                            count_d = count_q - ONE;
                        end else begin
                            count_d = count_q + ONE;
                        end
                    end else begin
                        term = (count_q == '0);
                        if (term) begin
                            dir_d   = 1'b0;
                            count_d = count_q + ONE;
                        end else begin
                            count_d = count_q - ONE;
                        end
                    end
                end
                MODE_HOLD: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q  <= MODE_UP;
            wrap_q  <= 1'b1;
            dir_q   <= 1'b0;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            tc_q    <= term && !load;
            count_q <= load ? cfg_value_i : count_d;
            dir_q   <= cfg_we_i ? 1'b0 : dir_d;
            if (cfg_we_i) begin
                mode_q <= mode_e'(cfg_mode_i);
                wrap_q <= cfg_wrap_i;
            end
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;

endmodule

// File: rtl/multi_counter.sv
// N_CH independent counters sharing one programmable prescaler tick.
// Ports: clk_i, rst_i, en_i, cfg_* channel config, div_we_i/div_i -> count_o, tc_o.
module multi_counter
    import counter_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int WIDTH = 8,
    parameter int DIV_W = 8,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_CH-1:0]       en_i,
    input  logic                  cfg_we_i,
    input  logic [CH_W-1:0]       cfg_ch_i,
    input  logic [MODE_W-1:0]     cfg_mode_i,
    input  logic                  cfg_wrap_i,
    input  logic                  cfg_load_i,
    input  logic [WIDTH-1:0]      cfg_value_i,
    input  logic                  div_we_i,
    input  logic [DIV_W-1:0]      div_i,
    output logic [N_CH*WIDTH-1:0] count_o,
    output logic [N_CH-1:0]       tc_o
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] presc_q;
    logic             tick;

    // A divider write restarts the prescaler, so that cycle never ticks
    assign tick = !div_we_i && (presc_q == div_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q   <= '0;
            presc_q <= '0;
        end else if (div_we_i) begin
            div_q   <= div_i;
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + DIV_W'(1);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic hit;

        // Out-of-range channel numbers match no instance
        assign hit = cfg_we_i && (cfg_ch_i == CH_W'(i));

        counter_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .step_i     (tick && en_i[i]),
            .cfg_we_i   (hit),
            .cfg_load_i (cfg_load_i),
            .cfg_mode_i (cfg_mode_i),
            .cfg_wrap_i (cfg_wrap_i),
            .cfg_value_i(cfg_value_i),
            .count_o    (count_o[i*WIDTH +: WIDTH]),
            .tc_o       (tc_o[i])
        );
    end

endmodule
